// File: rtl/fp_pkg.sv
// Shared widths, limits and FSM encoding for the add/subtract post-normalizer.
package fp_pkg;

  localparam int MANT_W   = 24;
  localparam int EXP_W    = 8;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int NORM_MAX = 23;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } fp_state_e;

  // Truncating pack: a mantissa without its hidden bit is a subnormal (exponent field 0).
  function automatic logic [31:0] pack_fp(input logic s, input logic [MANT_W-1:0] m,
                                          input logic [EXP_W-1:0] e);
    return {s, (m[MANT_W-1] ? e : 8'h00), m[MANT_W-2:0]};
  endfunction

endpackage

// File: rtl/fp_postnorm_addsub_if.sv
// Operand/result handshake bundle between the aligner and the post-normalizer.
interface fp_postnorm_addsub_if;
  import fp_pkg::*;

  logic [MANT_W-1:0] FP_norm1;
  logic [MANT_W-1:0] FP_norm2;
  logic [EXP_W-1:0]  main_exponent;
  logic              sign1;
  logic              sign2;
  logic              calc_mode;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       FP_out;
  logic              out_valid;
  logic              out_ready;
  logic              overflow;

  modport master (
    output FP_norm1, FP_norm2, main_exponent, sign1, sign2, calc_mode, in_valid, out_ready,
    input  in_ready, FP_out, out_valid, overflow
  );

  modport slave (
    input  FP_norm1, FP_norm2, main_exponent, sign1, sign2, calc_mode, in_valid, out_ready,
    output in_ready, FP_out, out_valid, overflow
  );

endinterface

// File: rtl/fp_mant_addsub.sv
// Signed-magnitude mantissa add/subtract; result magnitude carries one extra bit for the sum carry.
module fp_mant_addsub
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] op_a,
  input  logic [MANT_W-1:0] op_b,
  input  logic              sign_a,
  input  logic              sign_b,
  output logic [MANT_W:0]   mag,
  output logic              sign
);

  always_comb begin
    mag  = '0;
    sign = 1'b0;
    if (sign_a == sign_b) begin
      mag  = {1'b0, op_a} + {1'b0, op_b};
      sign = sign_a;
    end else if (op_a > op_b) begin
      mag  = {1'b0, op_a - op_b};
      sign = sign_a;
    end else if (op_b > op_a) begin
      mag  = {1'b0, op_b - op_a};
      sign = sign_b;
    end
    // exact cancellation leaves +0
  end

endmodule

// File: rtl/fp_postnorm_addsub.sv
// Post-normalizing FP32 add/subtract of pre-aligned mantissas, one bundle in flight.
//   state  | meaning
//   S_IDLE | waiting for an operand bundle, in_ready high
//   S_ADD  | mantissa add/subtract, carry renormalize, overflow/zero detect
//   S_NORM | left-shift one bit per cycle until hidden bit set or e == 1
//   S_DONE | result held on FP_out until out_ready
module fp_postnorm_addsub
  import fp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  fp_postnorm_addsub_if.slave bus
);

  fp_state_e         state;
  logic [MANT_W-1:0] op_a;
  logic [MANT_W-1:0] op_b;
  logic              sign_a;
  logic              sign_b_eff;
  logic [MANT_W-1:0] mant;
  logic [EXP_W:0]    e;
  logic [EXP_W:0]    e_inc;
  logic              res_sign;
  logic [4:0]        norm_cnt;
  logic [MANT_W:0]   sum_mag;
  logic              sum_sign;
  logic [31:0]       fp_out_r;
  logic              out_valid_r;
  logic              overflow_r;

  fp_mant_addsub u_mant (
    .op_a   (op_a),
    .op_b   (op_b),
    .sign_a (sign_a),
    .sign_b (sign_b_eff),
    .mag    (sum_mag),
    .sign   (sum_sign)
  );

  assign e_inc         = e + 9'd1;
  assign bus.in_ready  = rst_n & (state == S_IDLE);
  assign bus.FP_out    = fp_out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.overflow  = overflow_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_a        <= '0;
      op_b        <= '0;
      sign_a      <= 1'b0;
      sign_b_eff  <= 1'b0;
      mant        <= '0;
      e           <= '0;
      res_sign    <= 1'b0;
      norm_cnt    <= '0;
      fp_out_r    <= '0;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_a       <= bus.FP_norm1;
            op_b       <= bus.FP_norm2;
            sign_a     <= bus.sign1;
            sign_b_eff <= bus.sign2 ^ bus.calc_mode;
            e          <= (bus.main_exponent == '0) ? 9'd1 : {1'b0, bus.main_exponent};
            overflow_r <= 1'b0;
            state      <= S_ADD;
          end
        end
        S_ADD: begin
          res_sign <= sum_sign;
          norm_cnt <= 5'(NORM_MAX);
          if (sum_mag[MANT_W]) begin
            if (e_inc >= {1'b0, EXP_MAX}) begin
              fp_out_r    <= {sum_sign, EXP_MAX, 23'b0};
              overflow_r  <= 1'b1;
              out_valid_r <= 1'b1;
              state       <= S_DONE;
            end else begin
              mant  <= sum_mag[MANT_W:1];
              e     <= e_inc;
              state <= S_NORM;
            end
          end else if (sum_mag == '0) begin
            fp_out_r    <= '0;
            out_valid_r <= 1'b1;
            state       <= S_DONE;
          end else begin
            mant  <= sum_mag[MANT_W-1:0];
            state <= S_NORM;
          end
        end
        S_NORM: begin
          // norm_cnt is a safety stop; a nonzero mantissa never needs more shifts
          if (!mant[MANT_W-1] && (e > 9'd1) && (norm_cnt != 5'd0)) begin
            mant     <= {mant[MANT_W-2:0], 1'b0};
            e        <= e - 9'd1;
            norm_cnt <= norm_cnt - 5'd1;
          end else begin
            fp_out_r    <= pack_fp(res_sign, mant, e[EXP_W-1:0]);
            out_valid_r <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_postnorm_addsub.sv
// Directed and random checks of fp_postnorm_addsub against an integer-arithmetic reference.
module tb_fp_postnorm_addsub;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  fp_postnorm_addsub_if bus ();

  fp_postnorm_addsub dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: treat mantissas as signed integers, then renormalize by plain arithmetic.
  function automatic void model(input logic [23:0] a, input logic [23:0] b, input logic [7:0] ex,
                                input logic s1, input logic s2, input logic md,
                                output logic [31:0] res, output logic ov, output int k,
                                output bit special);
    longint va, vb, r, mag;
    int     ev;
    logic   sg;
    ev      = (ex == 8'd0) ? 1 : int'(ex);
    va      = s1 ? -longint'(a) : longint'(a);
    vb      = (s2 ^ md) ? -longint'(b) : longint'(b);
    r       = va + vb;
    sg      = (r < 0);
    mag     = sg ? -r : r;
    k       = 0;
    ov      = 1'b0;
    special = 1'b0;
    res     = '0;
    if (mag >= 64'd16777216) begin
      mag = mag / 2;
      ev  = ev + 1;
      if (ev >= 255) begin
        res     = {sg, 8'hFF, 23'b0};
        ov      = 1'b1;
        special = 1'b1;
        return;
      end
    end
    if (mag == 0) begin
      special = 1'b1;
      return;
    end
    while (mag < 64'd8388608 && ev > 1) begin
      mag = mag * 2;
      ev  = ev - 1;
      k++;
    end
    res = {sg, (mag >= 64'd8388608) ? 8'(ev) : 8'h00, 23'(mag)};
  endfunction

  // One bundle end to end; latency counted in edges after the acceptance edge.
  task automatic run(input string tag, input logic [23:0] a, input logic [23:0] b,
                     input logic [7:0] ex, input logic s1, input logic s2, input logic md,
                     input int bp);
    logic [31:0] er;
    logic        eo;
    int          ek;
    bit          sp;
    int          cnt;
    model(a, b, ex, s1, s2, md, er, eo, ek, sp);
    @(negedge clk);
    bus.FP_norm1      = a;
    bus.FP_norm2      = b;
    bus.main_exponent = ex;
    bus.sign1         = s1;
    bus.sign2         = s2;
    bus.calc_mode     = md;
    bus.in_valid      = 1'b1;
    cnt = 0;
    while (!bus.in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    cnt = 0;
    while (!bus.out_valid && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    // normal path: acceptance edge plus ADD edge plus (k+1) NORM edges = 3+k edges inclusive
    chk({tag, "_latency"}, 32'(cnt + 1), sp ? 32'd2 : 32'(3 + ek));
    chk({tag, "_fp_out"}, bus.FP_out, er);
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(eo));
    for (int i = 0; i < bp; i++) begin
      bus.in_valid = i[0];
      bus.FP_norm1 = 24'($urandom);
      @(negedge clk);
      chk({tag, "_hold_out"}, bus.FP_out, er);
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_drain_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [23:0] ra, rb;
    logic [7:0]  rex;
    int          pick;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.FP_norm1      = '0;
    bus.FP_norm2      = '0;
    bus.main_exponent = '0;
    bus.sign1         = 1'b0;
    bus.sign2         = 1'b0;
    bus.calc_mode     = 1'b0;
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_fp_out", bus.FP_out, 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    run("one_plus_one", 24'h800000, 24'h800000, 8'h7F, 1'b0, 1'b0, 1'b0, 0);
    run("1p5_minus_1",  24'hC00000, 24'h800000, 8'h7F, 1'b0, 1'b0, 1'b1, 0);
    run("cancel",       24'hA00000, 24'hA00000, 8'h80, 1'b0, 1'b0, 1'b1, 0);
    run("overflow",     24'h800000, 24'h800000, 8'hFE, 1'b0, 1'b0, 1'b0, 0);
    run("neg_ovf",      24'hFFFFFF, 24'h800000, 8'hFE, 1'b1, 1'b0, 1'b1, 0);
    run("backpress",    24'hC00000, 24'h400000, 8'h90, 1'b1, 1'b1, 1'b0, 5);
    run("subnormal",    24'h400000, 24'h300000, 8'h00, 1'b0, 1'b1, 1'b0, 0);
    run("sub_neg",      24'h800000, 24'hC00000, 8'h05, 1'b0, 1'b0, 1'b1, 1);

    // Reset during the second NORM cycle of a long normalization
    @(negedge clk);
    bus.FP_norm1      = 24'h800001;
    bus.FP_norm2      = 24'h800000;
    bus.main_exponent = 8'h80;
    bus.sign1         = 1'b0;
    bus.sign2         = 1'b0;
    bus.calc_mode     = 1'b1;
    bus.in_valid      = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_fp_out", bus.FP_out, 32'h0);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_ovf", 32'(bus.overflow), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_rel_ready", 32'(bus.in_ready), 32'd1);
    repeat (30) @(negedge clk);
    chk("midrst_no_result", 32'(bus.out_valid), 32'd0);
    run("post_rst", 24'h800001, 24'h800000, 8'h80, 1'b0, 1'b0, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      rex  = 8'($urandom_range(0, 254));
      ra   = {(rex != 8'd0), 23'($urandom)};
      pick = $urandom_range(0, 3);
      case (pick)
        0:       rb = {(rex != 8'd0), 23'($urandom)};
        1:       rb = ra;
        2:       rb = ra ^ 24'($urandom_range(1, 255));
        default: rb = {1'b0, 23'($urandom)};
      endcase
      run("rand", ra, rb, rex, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_postnorm_addsub.md
FP_POSTNORM_ADDSUB -- requirements
Module: fp_postnorm_addsub

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port FP_norm1, input, 24 bits: aligned mantissa of operand 1, hidden bit at [23].
REQ-004 SHALL have port FP_norm2, input, 24 bits: aligned mantissa of operand 2, hidden bit at [23].
REQ-005 SHALL have port main_exponent, input, 8 bits: common biased exponent of both mantissas.
REQ-006 SHALL have ports sign1 and sign2, input, 1 bit each: original operand signs.
REQ-007 SHALL have port calc_mode, input, 1 bit: 0 = add, 1 = subtract (op1 - op2).
REQ-008 SHALL have port in_valid, input, 1 bit: operand bundle valid.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts a bundle.
REQ-010 SHALL have port FP_out, output, 32 bits: packed IEEE-754 single result.
REQ-011 SHALL have port out_valid, output, 1 bit: FP_out valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port overflow, output, 1 bit: result saturated to infinity; qualified by out_valid.

Function
REQ-014 SHALL implement FSM IDLE -> ADD -> NORM -> DONE -> IDLE, one bundle in flight.
REQ-015 SHALL assert in_ready only in IDLE; acceptance = in_valid & in_ready on a rising edge; inputs latched, state -> ADD.
REQ-016 SHALL ignore in_valid outside IDLE; no bundle is dropped, because in_ready is low.
REQ-017 SHALL compute effective sign2 = sign2 ^ calc_mode and eff_sub = sign1 ^ effective sign2.
REQ-018 SHALL use internal exponent e = 1 when main_exponent == 0 (subnormal), else e = main_exponent.
REQ-019 ADD, eff_sub=0: 25-bit sum; if sum[24]=1 then mantissa = sum >> 1 and e = e + 1; result sign = sign1.
REQ-020 ADD, eff_sub=1: larger minus smaller magnitude; sign = sign of larger; equal magnitudes -> zero result with sign 0.
REQ-021 ADD: if e+1 reaches 255 -> FP_out = {sign, 8'hFF, 23'b0}, overflow = 1, state -> DONE.
REQ-022 ADD: zero mantissa -> FP_out = 32'h00000000, state -> DONE, NORM skipped.
REQ-023 NORM: per cycle, if mant[23]=0 and e>1, shift mant left 1 and e = e - 1; else pack and state -> DONE.
REQ-024 NORM is bounded to at most 23 shift cycles.
REQ-025 Pack: exponent field = (mant[23] ? e : 0), fraction = mant[22:0]; truncation, no rounding.
REQ-026 SHALL assert out_valid only in DONE; FP_out and overflow SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 DONE & out_ready -> IDLE; in_ready rises the next cycle (no same-cycle re-accept).
REQ-028 Latency SHALL be 3 + k edges from the acceptance edge to the edge that raises out_valid, k = NORM shift count.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, regardless of state, including mid-NORM.
REQ-030 rst_n low SHALL clear FP_out = 0, out_valid = 0, overflow = 0, and all internal registers.
REQ-031 in_ready SHALL be 0 while rst_n is low and 1 on the first cycle after release.

Structure
REQ-032 Package fp_pkg SHALL hold: FSM state enum, MANT_W=24, EXP_W=8, EXP_MAX=8'hFF, NORM_MAX=23.
REQ-033 Sub-module fp_mant_addsub (combinational) SHALL perform the compare/add/subtract, returning a 25-bit magnitude and sign.

Verification
REQ-034 1.0+1.0: norm1=norm2=24'h800000, exp=8'h7F, mode 0, signs 0 -> FP_out=32'h40000000, k=0.
REQ-035 1.5-1.0: norm1=24'hC00000, norm2=24'h800000, exp=8'h7F, mode 1 -> FP_out=32'h3F000000, k=1, latency 4.
REQ-036 Cancel: norm1=norm2=24'hA00000, exp=8'h80, mode 1 -> FP_out=32'h00000000, overflow=0.
REQ-037 Overflow: norm1=norm2=24'h800000, exp=8'hFE, mode 0 -> FP_out=32'h7F800000, overflow=1.
REQ-038 Backpressure: out_ready=0 for 5 cycles after out_valid -> FP_out stable, in_ready=0, in_valid pulses ignored.
REQ-039 Reset mid-NORM: norm1=24'h800001, norm2=24'h800000, mode 1, rst_n low on 2nd NORM cycle -> all outputs 0, IDLE; next bundle correct.
